// File: rtl/capt_memif.sv
// capt_memif: SRAM interface downstream of the camera capture block.
// Capture writes are posted into a small FIFO and never stall; display
// reads are granted in the gaps, with a starvation limit on consecutive
// writes while a read is pending. All SRAM-side outputs are registered.
// Optional build macro MEMIF_ERRCHK_EN adds a capture strobe timing checker
// that drives ERRFLAG; without it ERRFLAG is tied low.
module capt_memif #(
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned WR_CYC      = 3,
  parameter int unsigned RD_CYC      = 4,
  parameter int unsigned RD_STARVE   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [22:0] CMEMADDR,
  input  logic [15:0] CMEMDOUT,
  input  logic        CMEMnWE_asrt,
  input  logic        CMEMnWE_deas,
  input  logic        DREQ,
  input  logic [22:0] DADDR,
  output logic        DACK,
  output logic [15:0] DRDATA,
  output logic [22:0] MEMADDR,
  output logic [15:0] MEMDOUT,
  input  logic [15:0] MEMDIN,
  output logic        MEMDOE,
  output logic        MEMnCE,
  output logic        MEMnOE,
  output logic        MEMnWE,
  output logic        WFULL,
  output logic        WOVF,
  output logic        ERRFLAG
);

  localparam int unsigned AW   = $clog2(WFIFO_DEPTH);
  localparam int unsigned SW   = $clog2(RD_STARVE + 2);
  localparam int unsigned MAXC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [AW:0]   L_FULL    = (AW + 1)'(WFIFO_DEPTH);
  localparam logic [SW-1:0] L_STARVE  = SW'(RD_STARVE);
  localparam logic [CW-1:0] L_WR_LAST = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] L_RD_LAST = CW'(RD_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WREC, S_RD, S_RREC} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;

  logic [38:0]   r_fifo [WFIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_grant;
  logic          w_rd_grant;
  logic          w_push;
  logic [38:0]   w_head;

  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign WFULL   = w_full;
  assign w_head  = r_fifo[r_rp];

  assign w_wr_grant = (r_state == S_IDLE) && !w_empty && !(DREQ && (r_starve == L_STARVE));
  assign w_rd_grant = (r_state == S_IDLE) && !w_wr_grant && DREQ;
  // a full FIFO still accepts a push when the head is popped in the same cycle
  assign w_push     = CMEMnWE_asrt && (!w_full || w_wr_grant);

  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wp] <= {CMEMADDR, CMEMDOUT};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      WOVF    <= 1'b0;
    end else begin
      if (w_push)     r_wp <= r_wp + 1'b1;
      if (w_wr_grant) r_rp <= r_rp + 1'b1;
      case ({w_push, w_wr_grant})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (CMEMnWE_asrt && !w_push) WOVF <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)            r_starve <= '0;
    else if (!DREQ)      r_starve <= '0;
    else if (w_wr_grant) r_starve <= r_starve + 1'b1;
    else if (w_rd_grant) r_starve <= '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      MEMnCE  <= 1'b1;
      MEMnOE  <= 1'b1;
      MEMnWE  <= 1'b1;
      MEMDOE  <= 1'b0;
      MEMADDR <= '0;
      MEMDOUT <= '0;
      DACK    <= 1'b0;
      DRDATA  <= '0;
    end else begin
      DACK <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_wr_grant) begin
            r_state <= S_WR;
            MEMADDR <= w_head[38:16];
            MEMDOUT <= w_head[15:0];
            MEMnCE  <= 1'b0;
            MEMnWE  <= 1'b0;
            MEMDOE  <= 1'b1;
          end else if (w_rd_grant) begin
            r_state <= S_RD;
            MEMADDR <= DADDR;
            MEMnCE  <= 1'b0;
            MEMnOE  <= 1'b0;
            MEMDOE  <= 1'b0;
          end
        end
        S_WR: begin
          if (r_cnt == L_WR_LAST) begin
            r_state <= S_WREC;
            MEMnWE  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WREC: begin
          r_state <= S_IDLE;
          MEMnCE  <= 1'b1;
          MEMDOE  <= 1'b0;
        end
        S_RD: begin
          if (r_cnt == L_RD_LAST) begin
            r_state <= S_RREC;
            DRDATA  <= MEMDIN;
            MEMnCE  <= 1'b1;
            MEMnOE  <= 1'b1;
            DACK    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RREC: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEMIF_ERRCHK_EN
  logic       r_pend;
  logic [1:0] r_age;
  logic       w_resolve;

  // the outstanding asrt is closed this cycle by its deas or by timing out
  assign w_resolve = r_pend && (CMEMnWE_deas || (r_age == 2'd3));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pend  <= 1'b0;
      r_age   <= '0;
      ERRFLAG <= 1'b0;
    end else begin
      if (r_pend) begin
        if (CMEMnWE_deas) begin
          if (r_age != 2'd3) ERRFLAG <= 1'b1;
        end else if (r_age == 2'd3) begin
          ERRFLAG <= 1'b1;
        end
      end else if (CMEMnWE_deas) begin
        ERRFLAG <= 1'b1;
      end
      if (CMEMnWE_asrt) begin
        if (r_pend && !w_resolve) ERRFLAG <= 1'b1;
        r_pend <= 1'b1;
        r_age  <= 2'd1;
      end else if (w_resolve) begin
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_age <= r_age + 1'b1;
      end
    end
  end
`else
  logic w_unused_deas;
  assign w_unused_deas = CMEMnWE_deas;
  assign ERRFLAG       = 1'b0;
`endif

endmodule

// File: tb/tb_capt_memif.sv
// Directed self-checking bench for capt_memif at default parameters.
// Honours MEMIF_ERRCHK_EN for the ERRFLAG expectations.
module tb_capt_memif;

  logic        CLK;
  logic        RST;
  logic [22:0] CMEMADDR;
  logic [15:0] CMEMDOUT;
  logic        CMEMnWE_asrt;
  logic        CMEMnWE_deas;
  logic        DREQ;
  logic [22:0] DADDR;
  logic        DACK;
  logic [15:0] DRDATA;
  logic [22:0] MEMADDR;
  logic [15:0] MEMDOUT;
  logic [15:0] MEMDIN;
  logic        MEMDOE;
  logic        MEMnCE;
  logic        MEMnOE;
  logic        MEMnWE;
  logic        WFULL;
  logic        WOVF;
  logic        ERRFLAG;

`ifdef MEMIF_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  capt_memif #(
    .WFIFO_DEPTH(4),
    .WR_CYC     (3),
    .RD_CYC     (4),
    .RD_STARVE  (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CMEMADDR    (CMEMADDR),
    .CMEMDOUT    (CMEMDOUT),
    .CMEMnWE_asrt(CMEMnWE_asrt),
    .CMEMnWE_deas(CMEMnWE_deas),
    .DREQ        (DREQ),
    .DADDR       (DADDR),
    .DACK        (DACK),
    .DRDATA      (DRDATA),
    .MEMADDR     (MEMADDR),
    .MEMDOUT     (MEMDOUT),
    .MEMDIN      (MEMDIN),
    .MEMDOE      (MEMDOE),
    .MEMnCE      (MEMnCE),
    .MEMnOE      (MEMnOE),
    .MEMnWE      (MEMnWE),
    .WFULL       (WFULL),
    .WOVF        (WOVF),
    .ERRFLAG     (ERRFLAG)
  );

  // SRAM model: read data is a fixed scramble of the address (0x00ABCD -> 0x1234)
  assign MEMDIN = MEMnOE ? 16'hDEAD : (MEMADDR[15:0] ^ 16'hB9F9);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [38:0] q_exp [$];
  int unsigned q_cyc [$];
  bit          ev_log [$];
  bit          lat_chk = 1'b0;
  bit          log_en  = 1'b0;

  // SRAM-side monitor: write order/content/length, read data, OE/DOE exclusion
  logic        m_prev_nwe = 1'b1;
  int unsigned m_lowcnt   = 0;
  logic [38:0] m_cur      = '0;
  int unsigned m_c0       = 0;
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      m_prev_nwe = 1'b1;
      m_lowcnt   = 0;
    end else begin
      if (!MEMnOE) chk("oe_doe_excl", MEMDOE, 1'b0);
      if (!MEMnWE && m_prev_nwe) begin
        m_lowcnt = 1;
        chk("wr_pending", q_exp.size() != 0, 1'b1);
        if (q_exp.size() != 0) begin
          m_cur = q_exp.pop_front();
          m_c0  = q_cyc.pop_front();
          chk("wr_addr", MEMADDR, m_cur[38:16]);
          chk("wr_data", MEMDOUT, m_cur[15:0]);
          if (lat_chk) chk("wr_latency", cyc - m_c0, 2);
          if (log_en) ev_log.push_back(1'b1);
        end
      end else if (!MEMnWE) begin
        m_lowcnt++;
      end else if (!m_prev_nwe) begin
        chk("wr_nwe_len", m_lowcnt, 3);
        chk("wrec_hold", {MEMnCE, MEMDOE, MEMADDR, MEMDOUT}, {1'b0, 1'b1, m_cur});
      end
      if (DACK) begin
        chk("rd_data", DRDATA, DADDR[15:0] ^ 16'hB9F9);
        if (log_en) ev_log.push_back(1'b0);
      end
      m_prev_nwe = MEMnWE;
    end
  end

  // one capture write: asrt now, deas 3 cycles later, returns 5 cycles later
  task automatic cap_write(input logic [22:0] a, input logic [15:0] d, input bit drop);
    CMEMADDR     = a;
    CMEMDOUT     = d;
    CMEMnWE_asrt = 1'b1;
    if (!drop) begin
      q_exp.push_back({a, d});
      q_cyc.push_back(cyc);
    end
    tick();
    CMEMnWE_asrt = 1'b0;
    tick();
    tick();
    CMEMnWE_deas = 1'b1;
    tick();
    CMEMnWE_deas = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, {MEMnCE, MEMnOE, MEMnWE, MEMDOE}, 4'b1110);
    chk({tag, "_addr"}, MEMADDR, 23'h0);
    chk({tag, "_dout"}, MEMDOUT, 16'h0);
    chk({tag, "_dack"}, DACK, 1'b0);
    chk({tag, "_drdata"}, DRDATA, 16'h0);
    chk({tag, "_flags"}, {WFULL, WOVF, ERRFLAG}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          first_low;
    int unsigned low_cnt;
    int unsigned oe_cnt;
    int unsigned dack_cnt;
    int unsigned dack_at;
    logic [8:0]  pat;
    bit          seen;

    RST          = 1'b0;
    CMEMADDR     = '0;
    CMEMDOUT     = '0;
    CMEMnWE_asrt = 1'b0;
    CMEMnWE_deas = 1'b0;
    DREQ         = 1'b0;
    DADDR        = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    RST = 1'b1;
    repeat (2) tick();

    // 1: single write timing and content
    CMEMADDR     = 23'h000123;
    CMEMDOUT     = 16'hA5A5;
    CMEMnWE_asrt = 1'b1;
    q_exp.push_back({23'h000123, 16'hA5A5});
    q_cyc.push_back(cyc);
    first_low = -1;
    low_cnt   = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) CMEMnWE_asrt = 1'b0;
      if (i == 3) CMEMnWE_deas = 1'b1;
      if (i == 4) CMEMnWE_deas = 1'b0;
      if (!MEMnWE) begin
        if (first_low < 0) first_low = i;
        low_cnt++;
        chk("t1_addr", MEMADDR, 23'h000123);
        chk("t1_dout", MEMDOUT, 16'hA5A5);
      end
    end
    chk("t1_first_low", first_low, 2);
    chk("t1_low_cnt", low_cnt, 3);
    chk("t1_wovf", WOVF, 1'b0);
    repeat (3) tick();

    // 2: 600 back-to-back capture writes, each issued 2 cycles after its asrt
    lat_chk = 1'b1;
    for (int i = 0; i < 600; i++)
      cap_write(23'(32'h100 + i * 3), 16'(i) ^ 16'h5A5A, 1'b0);
    repeat (4) tick();
    lat_chk = 1'b0;
    chk("t2_all_written", q_exp.size(), 0);
    chk("t2_wovf", WOVF, 1'b0);
    chk("t2_wfull", WFULL, 1'b0);

    // 3: read with the FIFO empty; DREQ first seen in cycle 1
    DADDR    = 23'h00ABCD;
    DREQ     = 1'b1;
    oe_cnt   = 0;
    dack_cnt = 0;
    dack_at  = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!MEMnOE) begin
        oe_cnt++;
        if (oe_cnt == 1) chk("t3_addr", MEMADDR, 23'h00ABCD);
      end
      if (DACK) begin
        dack_cnt++;
        dack_at = i + 1;
        chk("t3_drdata", DRDATA, 16'h1234);
        DREQ = 1'b0;
      end
    end
    chk("t3_oe_cycles", oe_cnt, 4);
    chk("t3_dack_cycle", dack_at, 6);
    chk("t3_dack_count", dack_cnt, 1);

    // 4: writes every 5 cycles with DREQ held; the 11th asrt lands full during a read
    DADDR  = 23'h001000;
    DREQ   = 1'b1;
    log_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 6) chk("t4_not_full_early", WFULL, 1'b0);
      if (i == 10) begin
        chk("t4_wfull", WFULL, 1'b1);
        chk("t4_wovf_before", WOVF, 1'b0);
        chk("t4_in_read", MEMnOE, 1'b0);
      end
      cap_write(23'(32'h2000 + i), 16'(32'hC000 + i), i == 10);
    end
    chk("t4_wovf_after", WOVF, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if (q_exp.size() == 0) break;
      tick();
    end
    chk("t4_drain", q_exp.size(), 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (DACK) begin
        DREQ = 1'b0;
        seen = 1'b1;
        break;
      end
    end
    chk("t4_final_dack", seen, 1'b1);
    repeat (12) tick();
    log_en = 1'b0;
    chk("t4_event_count", ev_log.size() >= 9, 1'b1);
    pat = '0;
    for (int j = 0; j < 9; j++)
      if (j < ev_log.size()) pat = {pat[7:0], ev_log[j]};
    chk("t4_grant_order", pat, 9'b011011011);
    chk("t4_wovf_sticky", WOVF, 1'b1);

    // 5: asynchronous reset in the middle of a write
    CMEMADDR     = 23'h000777;
    CMEMDOUT     = 16'h7777;
    CMEMnWE_asrt = 1'b1;
    q_exp.push_back({23'h000777, 16'h7777});
    q_cyc.push_back(cyc);
    tick();
    CMEMnWE_asrt = 1'b0;
    tick();
    tick();
    chk("t5_in_write", MEMnWE, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    tick();
    tick();
    #3;
    RST = 1'b1;
    tick();
    cap_write(23'h000888, 16'h8888, 1'b0);
    repeat (5) tick();
    chk("t5_rewrite_done", q_exp.size(), 0);
    chk("t5_wovf", WOVF, 1'b0);

    // 6: capture strobe spacing checker
    cap_write(23'h000010, 16'h0010, 1'b0);
    chk("t6_err_good", ERRFLAG, 1'b0);
    CMEMADDR     = 23'h000011;
    CMEMDOUT     = 16'h0011;
    CMEMnWE_asrt = 1'b1;
    q_exp.push_back({23'h000011, 16'h0011});
    q_cyc.push_back(cyc);
    tick();
    CMEMnWE_asrt = 1'b0;
    tick();
    CMEMnWE_deas = 1'b1;
    tick();
    CMEMnWE_deas = 1'b0;
    tick();
    tick();
    chk("t6_err_early", ERRFLAG, ERR_EXP);
    cap_write(23'h000012, 16'h0012, 1'b0);
    repeat (5) tick();
    chk("t6_err_sticky", ERRFLAG, ERR_EXP);
    chk("t6_writes_done", q_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/capt_memif.md
Name: capt_memif

Overview:
SRAM interface stage directly downstream of the camera capture block. It accepts the capture block's fixed-timing write strobes (CMEMADDR/CMEMDOUT/CMEMnWE_asrt/CMEMnWE_deas) into a small posting FIFO. It arbitrates those writes against a display-side read port and drives the external asynchronous 16-bit SRAM pins. Capture writes never stall; display reads fill the gaps.

Parameters:
WFIFO_DEPTH, 4, write-posting FIFO entries; power of 2, >=2
WR_CYC, 3, cycles MEMnWE held low per write
RD_CYC, 4, cycles MEMnOE held low per read; MEMDIN sampled on last
RD_STARVE, 2, max consecutive writes granted while DREQ is pending

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
CMEMADDR  in  23  [23:1] capture write word address
CMEMDOUT  in  16  capture write data
CMEMnWE_asrt  in  1  capture write start strobe; 1 cycle
CMEMnWE_deas  in  1  capture write end strobe; 1 cycle
DREQ  in  1  display read request; held until DACK
DADDR  in  23  display read word address; stable while DREQ
DACK  out  1  1-cycle pulse; DRDATA valid this cycle
DRDATA  out  16  read data
MEMADDR  out  23  SRAM address
MEMDOUT  out  16  SRAM write data
MEMDIN  in  16  SRAM read data
MEMDOE  out  1  1 = drive MEMDOUT onto the bus
MEMnCE, MEMnOE, MEMnWE  out  1 each  SRAM strobes, active-low
WFULL  out  1  FIFO full, combinational from the count
WOVF  out  1  sticky: a capture write was dropped
ERRFLAG  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (RST=0, async): FIFO empty; FSM IDLE; MEMnCE/MEMnOE/MEMnWE=1; MEMDOE=0; MEMADDR=0; MEMDOUT=0; DACK=0; DRDATA=0; WOVF=0; ERRFLAG=0; starve count=0. Reset mid-cycle releases all strobes immediately; the in-flight transfer is lost.
- Push: in the cycle CMEMnWE_asrt=1, {CMEMADDR,CMEMDOUT} is written to the FIFO. The push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the entry is dropped and WOVF is set.
- CMEMnWE_deas does not affect the datapath.
- All SRAM-side outputs are registered.
- FSM states: IDLE, WR, WREC, RD, RREC.
- IDLE grant rule:
  - Grant a write (pop the FIFO head) if the FIFO is non-empty and NOT (DREQ=1 and starve count=RD_STARVE).
  - Otherwise grant a read if DREQ=1.
  - Otherwise stay in IDLE.
- WR: MEMADDR/MEMDOUT are loaded from the popped entry on entry. MEMnCE=0, MEMDOE=1, MEMnWE=0 for WR_CYC cycles, then go to WREC.
- WREC: 1 cycle with MEMnWE=1 while MEMnCE=0, MEMDOE=1 and the address/data are still held. Then go to IDLE with MEMnCE=1, MEMDOE=0.
- Starve count: increments on each write grant while DREQ=1; clears on a read grant or when DREQ=0.
- RD: MEMADDR<=DADDR; MEMnCE=0, MEMnOE=0, MEMDOE=0 for RD_CYC cycles. MEMDIN is registered into DRDATA on the last RD cycle. Then go to RREC.
- RREC: strobes are high, DACK=1 for this cycle only, then go to IDLE.
- A DREQ that drops mid-read is not supported; the read still completes and DACK still pulses.
- MEMDOE and MEMnOE are never both active. There is at least one cycle with all strobes high between a read and a write.
- Throughput at default parameters: a write takes 5 cycles (IDLE+3 WR+WREC), matching the capture rate of 1 write per 5 cycles.
- Read latency from IDLE with an empty FIFO: DACK arrives RD_CYC+2 cycles after DREQ is sampled.

Optional Feature:
- MEMIF_ERRCHK_EN defined:
  - Checks that each CMEMnWE_deas arrives exactly 3 cycles after CMEMnWE_asrt.
  - Sets ERRFLAG on a missing or early deas, or a deas with no preceding asrt.
  - Sets ERRFLAG on a second asrt before the pending deas.
  - ERRFLAG is sticky until reset.
- Not defined: ERRFLAG tied to 0 and the checker logic is absent.

Test Plan:
1. Single asrt, addr 0x000123, data 0xA5A5, FIFO empty, DREQ=0 -> MEMnWE low exactly 3 cycles starting 2 cycles after asrt; MEMADDR=0x000123, MEMDOUT=0xA5A5 throughout; WOVF=0.
2. 600 back-to-back capture writes (asrt every 5 cycles), DREQ=0 -> all 600 appear on the SRAM in order, FIFO count never exceeds 1, WOVF=0.
3. Read with the FIFO empty: DREQ, DADDR=0x00ABCD, model returns 0x1234 -> MEMnOE low 4 cycles, DACK pulses once at cycle 6, DRDATA=0x1234.
4. Continuous capture writes plus DREQ held -> a read is granted after every 2 writes, the FIFO reaches 4, WFULL asserts, and a further asrt while full with no pop sets WOVF=1 and drops that entry.
5. RST pulled low mid-WR -> MEMnWE/MEMnCE go high asynchronously, all outputs return to reset values; after release, a new asrt is written normally.
6. With MEMIF_ERRCHK_EN: deas arriving 2 cycles after asrt -> ERRFLAG=1, sticky; correct 3-cycle spacing keeps ERRFLAG=0. Without the macro: ERRFLAG=0 always.
